// File: rtl/jaleco_pkg.sv
// jaleco_pkg: shared types and constants for the Jaleco JF-17/JF-19 latch mapper.
//   spk_state_t : speech handshake FSM states
//   SS_*        : save-state register indices
package jaleco_pkg;

    typedef enum logic [1:0] {
        SPK_IDLE    = 2'd0,
        SPK_REQ     = 2'd1,
        SPK_RELEASE = 2'd2
    } spk_state_t;

    localparam logic [7:0] SS_PRG  = 8'd0;
    localparam logic [7:0] SS_CHR  = 8'd1;
    localparam logic [7:0] SS_STAT = 8'd2;
    localparam logic [7:0] SS_SPK  = 8'd3;
    localparam logic [7:0] SS_MAP  = 8'd127;

endpackage

// File: rtl/jf_speech_hs.sv
// jf_speech_hs: speech-command handshake toward an external ADPCM player.
// All state updates on the falling edge of m2 (CPU phi2).
// Ports:
//   m2_i, rst_n_i   : clock (falling edge), synchronous active-low reset
//   wr_i, d_i       : speech-register write strobe and effective write data
//   ack_i           : acknowledge from the sample player
//   stat_we_i       : save-state restore of {s_lat,drop,err,state}
//   spk_we_i        : save-state restore of the sample index
//   ss_wdat_i       : save-state write data
//   req_o, idx_o    : registered request and captured sample index
//   s_lat_o, drop_o, err_o, state_o : status for save-state readback
module jf_speech_hs
    import jaleco_pkg::*;
#(
    parameter int TMO_W = 12
) (
    input  logic       m2_i,
    input  logic       rst_n_i,
    input  logic       wr_i,
    input  logic [7:0] d_i,
    input  logic       ack_i,
    input  logic       stat_we_i,
    input  logic       spk_we_i,
    input  logic [7:0] ss_wdat_i,
    output logic       req_o,
    output logic [4:0] idx_o,
    output logic       s_lat_o,
    output logic       drop_o,
    output logic       err_o,
    output logic [1:0] state_o
);

    // Timeout fires on the edge where the counter would reach all-ones,
    // i.e. 2^TMO_W-1 edges after entering REQ/RELEASE.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    spk_state_t       state_q;
    logic             req_q;
    logic [TMO_W-1:0] tmo_q;
    logic [4:0]       idx_q;
    logic             s_lat_q, drop_q, err_q;

    logic tmo_hit;
    assign tmo_hit = (tmo_q == TMO_LAST);

    always_ff @(negedge m2_i) begin
        if (!rst_n_i) begin
            state_q <= SPK_IDLE;
            req_q   <= 1'b0;
            tmo_q   <= '0;
            idx_q   <= '0;
            s_lat_q <= 1'b0;
            drop_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (stat_we_i) begin
                s_lat_q <= ss_wdat_i[5];
                drop_q  <= ss_wdat_i[4];
                err_q   <= ss_wdat_i[3];
                state_q <= spk_state_t'(ss_wdat_i[2:1]);
                req_q   <= (ss_wdat_i[2:1] == SPK_REQ);
                tmo_q   <= '0;
            end else begin
                if (wr_i) begin
                    s_lat_q <= d_i[5];
                    if (d_i[5] && !s_lat_q) begin
                        if (state_q == SPK_IDLE) begin
                            idx_q   <= d_i[4:0];
                            state_q <= SPK_REQ;
                            req_q   <= 1'b1;
                            tmo_q   <= '0;
                        end else begin
                            drop_q  <= 1'b1;
                        end
                    end
                end
                case (state_q)
                    SPK_IDLE: ;
                    SPK_REQ: begin
                        if (ack_i) begin
                            state_q <= SPK_RELEASE;
                            req_q   <= 1'b0;
                            tmo_q   <= '0;
                        end else if (tmo_hit) begin
                            state_q <= SPK_IDLE;
                            req_q   <= 1'b0;
                            err_q   <= 1'b1;
                            tmo_q   <= '0;
                        end else begin
                            tmo_q   <= tmo_q + 1'b1;
                        end
                    end
                    SPK_RELEASE: begin
                        if (!ack_i) begin
                            state_q <= SPK_IDLE;
                            tmo_q   <= '0;
                        end else if (tmo_hit) begin
                            state_q <= SPK_IDLE;
                            err_q   <= 1'b1;
                            tmo_q   <= '0;
                        end else begin
                            tmo_q   <= tmo_q + 1'b1;
                        end
                    end
                    // A restored illegal encoding falls back to IDLE.
                    default: begin
                        state_q <= SPK_IDLE;
                        req_q   <= 1'b0;
                        tmo_q   <= '0;
                    end
                endcase
            end
            if (spk_we_i) idx_q <= ss_wdat_i[4:0];
        end
    end

    assign req_o   = req_q;
    assign idx_o   = idx_q;
    assign s_lat_o = s_lat_q;
    assign drop_o  = drop_q;
    assign err_o   = err_q;
    assign state_o = state_q;

    logic unused_bits;
    assign unused_bits = ^{ss_wdat_i[7:6], ss_wdat_i[0], d_i[7:6]};

endmodule

// File: rtl/jaleco_latch_map.sv
// jaleco_latch_map: edge-latch PRG/CHR bank mapper for Jaleco JF-17/JF-19
// (iNES 72 / 92). Banks reload only on a 0->1 transition of their latch bit.
// Optional feature macro: JF_SPEECH_EN (speech handshake at $6000-$7FFF).
// Ports:
//   m2, rst_n              : CPU phi2 (registers on falling edge), sync active-low reset
//   cpu_ce/rw/addr/dat     : CPU bus ($8000-$FFFF decode active low)
//   rom_dat                : PRG ROM data for bus-conflict masking
//   mode92                 : 0 = 72 layout, 1 = 92 layout
//   ss_act/we/addr, ss_rdat: save-state access
//   prg_hi, chr_hi         : upper PRG/CHR address bits
//   spk_req/idx/ack        : speech command handshake
module jaleco_latch_map
    import jaleco_pkg::*;
#(
    parameter int PRG_BW       = 4,
    parameter int CHR_BW       = 4,
    parameter int BUS_CONFLICT = 1,
    parameter int TMO_W        = 12
) (
    input  logic              m2,
    input  logic              rst_n,
    input  logic              cpu_ce,
    input  logic              cpu_rw,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_dat,
    input  logic [7:0]        rom_dat,
    input  logic              mode92,
    input  logic              ss_act,
    input  logic              ss_we,
    input  logic [7:0]        ss_addr,
    output logic [7:0]        ss_rdat,
    output logic [PRG_BW-1:0] prg_hi,
    output logic [CHR_BW-1:0] chr_hi,
    output logic              spk_req,
    output logic [4:0]        spk_idx,
    input  logic              spk_ack
);

    logic [PRG_BW-1:0] prg_q, prg_d;
    logic [CHR_BW-1:0] chr_q, chr_d;
    logic              p_lat_q, p_lat_d, c_lat_q, c_lat_d;
    logic [7:0]        d;
    logic              bus_we, ss_wr;
    logic [7:0]        stat_rd, spk_rd;

    assign d      = (BUS_CONFLICT != 0) ? (cpu_dat & rom_dat) : cpu_dat;
    assign bus_we = !ss_act && !cpu_ce && !cpu_rw;
    assign ss_wr  = ss_act && ss_we;

    always_comb begin
        prg_d   = prg_q;
        chr_d   = chr_q;
        p_lat_d = p_lat_q;
        c_lat_d = c_lat_q;
        if (ss_wr) begin
            case (ss_addr)
                SS_PRG:  prg_d = PRG_BW'(cpu_dat);
                SS_CHR:  chr_d = CHR_BW'(cpu_dat);
                SS_STAT: begin
                    p_lat_d = cpu_dat[7];
                    c_lat_d = cpu_dat[6];
                end
                default: ;
            endcase
        end else if (bus_we) begin
            p_lat_d = d[7];
            c_lat_d = d[6];
            // PRG bank field is the low nibble; wider banks get zero upper bits.
            if (!p_lat_q && d[7]) prg_d = PRG_BW'(d[3:0]);
            if (!c_lat_q && d[6]) chr_d = CHR_BW'(d);
        end
    end

    always_ff @(negedge m2) begin
        if (!rst_n) begin
            prg_q   <= '0;
            chr_q   <= '0;
            p_lat_q <= 1'b0;
            c_lat_q <= 1'b0;
        end else begin
            prg_q   <= prg_d;
            chr_q   <= chr_d;
            p_lat_q <= p_lat_d;
            c_lat_q <= c_lat_d;
        end
    end

    // 72 switches the low 16 KB window, 92 the high one; the other is fixed.
    always_comb begin
        if (mode92) prg_hi = cpu_addr[14] ? prg_q : '0;
        else        prg_hi = cpu_addr[14] ? '1 : prg_q;
    end
    assign chr_hi = chr_q;

`ifdef JF_SPEECH_EN
    logic       spk_wr, stat_we, spk_we;
    logic       s_lat, drop, err;
    logic [1:0] spk_st;

    // $6000-$7FFF writes; not part of the $8000 decode, so cpu_ce is ignored.
    assign spk_wr  = !ss_act && !cpu_rw && (cpu_addr[15:13] == 3'b011);
    assign stat_we = ss_wr && (ss_addr == SS_STAT);
    assign spk_we  = ss_wr && (ss_addr == SS_SPK);

    jf_speech_hs #(.TMO_W(TMO_W)) u_spk (
        .m2_i      (m2),
        .rst_n_i   (rst_n),
        .wr_i      (spk_wr),
        .d_i       (d),
        .ack_i     (spk_ack),
        .stat_we_i (stat_we),
        .spk_we_i  (spk_we),
        .ss_wdat_i (cpu_dat),
        .req_o     (spk_req),
        .idx_o     (spk_idx),
        .s_lat_o   (s_lat),
        .drop_o    (drop),
        .err_o     (err),
        .state_o   (spk_st)
    );

    assign stat_rd = {p_lat_q, c_lat_q, s_lat, drop, err, spk_st, 1'b0};
    assign spk_rd  = {3'b000, spk_idx};
`else
    assign spk_req = 1'b0;
    assign spk_idx = 5'd0;
    assign stat_rd = {p_lat_q, c_lat_q, 6'b0};
    assign spk_rd  = 8'hFF;

    logic unused_spk;
    assign unused_spk = ^{spk_ack, cpu_addr[15:13]};
`endif

    always_comb begin
        case (ss_addr)
            SS_PRG:  ss_rdat = 8'(prg_q);
            SS_CHR:  ss_rdat = 8'(chr_q);
            SS_STAT: ss_rdat = stat_rd;
            SS_SPK:  ss_rdat = spk_rd;
            SS_MAP:  ss_rdat = {7'b0, mode92};
            default: ss_rdat = 8'hFF;
        endcase
    end

    logic unused_top;
    assign unused_top = ^{d, cpu_dat, cpu_addr[13:0]};

endmodule

// File: doc/jaleco_latch_map.md
# jaleco_latch_map

Parametrised edge-latch bank mapper for the Jaleco JF-17/JF-19 board family (iNES 72 and 92), generalised in PRG/CHR bank width, with optional ROM/data bus-conflict masking and an optional speech-command handshake port. It sits behind the base bus/sys_cfg/ss_ctrl decode inside a mapper top. It supplies the upper PRG/CHR address bits, the save-state readback, and a request/ack command stream to an external ADPCM sample player.

## Interface
Parameters:
- PRG_BW, 4: PRG bank register width; PRG window is 16 KB.
- CHR_BW, 4: CHR bank register width; CHR window is 8 KB.
- BUS_CONFLICT, 1: 1 means effective write data = cpu_dat & rom_dat.
- TMO_W, 12: width of the speech handshake timeout counter.

Ports:
- m2  in  1  CPU phi2. Every register updates on the falling edge.
- rst_n  in  1  Reset. Synchronous, active-low, sampled on negedge m2.
- cpu_ce  in  1  Active-low decode of $8000-$FFFF.
- cpu_rw  in  1  1 = read.
- cpu_addr  in  16  CPU address.
- cpu_dat  in  8  CPU data bus; also carries save-state write data.
- rom_dat  in  8  PRG ROM output; used for bus-conflict masking.
- mode92  in  1  0 selects 72 layout, 1 selects 92 layout. Held static.
- ss_act, ss_we  in  1  Save-state access, save-state write.
- ss_addr  in  8  Save-state register index.
- ss_rdat  out  8  Save-state readback.
- prg_hi  out  PRG_BW  prg_addr[PRG_BW+13:14].
- chr_hi  out  CHR_BW  chr_addr[CHR_BW+12:13].
- spk_req  out  1  Speech request.
- spk_idx  out  5  Sample index.
- spk_ack  in  1  Speech acknowledge.

## Operation
- Write event: negedge m2 with rst_n=1, !ss_act, !cpu_ce and !cpu_rw. Effective data d = BUS_CONFLICT ? cpu_dat&rom_dat : cpu_dat.
- On each write event:
  - p_lat<=d[7] and c_lat<=d[6].
  - If p_lat==0 && d[7]==1, then prg<=d[PRG_BW-1:0], zero-padded when PRG_BW>4.
  - If c_lat==0 && d[6]==1, then chr<=d[CHR_BW-1:0].
  - A write with the bit already high does not reload the bank.
- PRG mapping, combinational:
  - 72 layout: cpu_addr[14]=0 gives prg, else all-ones.
  - 92 layout: cpu_addr[14]=1 gives prg, else zero.
- chr_hi = chr.
- Speech events are writes with cpu_addr[15:13]=3'b011 and rw=0. cpu_ce is not required for these. There is no bank effect.
  - s_lat<=d[5].
  - A rising edge of d[5] while state is IDLE captures spk_idx<=d[4:0] and moves to REQ.
  - A rising edge in any other state is dropped, and sticky drop<=1.
- Speech FSM states:
  - IDLE: spk_req=0.
  - REQ: spk_req=1 and tmo counts up. spk_ack=1 goes to RELEASE. tmo reaching all-ones goes to IDLE with sticky err<=1.
  - RELEASE: spk_req=0. spk_ack=0 goes to IDLE. The timeout also applies here.
  - tmo clears on every state change.
- Save state is active when ss_act=1; bus writes are then ignored.
  - Address 0 reads/writes prg.
  - Address 1 reads/writes chr.
  - Address 2 reads/writes {p_lat,c_lat,s_lat,drop,err,state[1:0],0}. A write restores all fields except the zero bit.
  - Address 3 reads/writes {3'b0,spk_idx}.
  - Address 127 reads {7'b0,mode92}.
  - All other addresses read 8'hFF.
  - Narrow fields zero-extend on read and truncate on write.
- drop and err clear on reset or on an ss write to address 2.

## Timing
- Reset (rst_n=0 at negedge m2):
  - prg, chr, p_lat, c_lat and s_lat go to 0.
  - state goes to IDLE; tmo, drop, err and spk_idx go to 0.
  - On the following edge: spk_req=0, prg_hi=0 (72: upper bank is still all-ones), chr_hi=0.
- Reset has priority over ss and bus writes. Reset during REQ drops spk_req on the same edge.
- Bank latency: prg_hi/chr_hi change after the negedge m2 that ends the write cycle. They are stable for the entire next cycle.
- spk_req asserts on the edge that captures the command and is registered. spk_ack is sampled on negedge m2 only. Minimum handshake is 3 edges.
- Timeout after 2^TMO_W−1 edges in REQ/RELEASE.
- Simultaneous d[7] and d[6] rising: both banks load on the same edge.

## Configuration
- JF_SPEECH_EN defined: speech decode, FSM, timeout counter, and save-state addresses 2 (speech fields) and 3 are present.
- JF_SPEECH_EN undefined:
  - spk_req is tied to 0 and spk_idx to 0.
  - Writes to $6000-$7FFF are ignored.
  - Address 2 holds only p_lat and c_lat; other bits read 0.
  - Address 3 reads 8'hFF.

## Structure
- Shared package jaleco_pkg holds:
  - the speech state enum (IDLE=0, REQ=1, RELEASE=2);
  - save-state index constants SS_PRG=0, SS_CHR=1, SS_STAT=2, SS_SPK=3, SS_MAP=127.
- One sub-module, jf_speech_hs, contains the FSM, timeout counter, drop/err flags and spk_idx register. It is instantiated only under JF_SPEECH_EN.

## Test plan
- Reset, then read at $8000 in 72 mode -> prg_hi=0. Read at $C000 -> prg_hi=all-ones, chr_hi=0, spk_req=0.
- Write $85 then $86 (mode 72) -> prg=5 after the first write. The second write does not reload; prg stays 5. Then write $05 followed by $83 -> prg=3.
- BUS_CONFLICT=1: write cpu_dat=$C7 with rom_dat=$4F -> d=$47. chr=7, prg unchanged. Then with rom_dat=$FF, write $C2 -> prg=2 (PRG latch rising), chr unchanged.
- Write $20|$0B to $6000 -> spk_req=1, spk_idx=11. Ack high -> req low. Ack low -> IDLE. A second start while in REQ sets drop=1 and spk_idx stays 11.
- Hold ack low for 2^TMO_W−1 edges after a start -> FSM returns to IDLE and err=1. Drive rst_n=0 mid-REQ -> spk_req=0 on that edge.
- ss write addr0=$09 and addr1=$0C, then read back -> $09 and $0C. Addr 127 in mode92 -> $01. Addr 50 -> $FF.
